// File: rtl/i2c_reg_ctrl.sv
// Register-write controller: turns the i2c slave byte stream (pointer byte, then data
// bytes) into auto-incrementing writes to a bank of 8-bit configuration registers.
module i2c_reg_ctrl #(
  parameter int NREGS = 8,
  parameter int PTR_W = 3,
  parameter int WRAP  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         data,
  input  logic               data_valid,
  input  logic               start,
  input  logic               stop,
  output logic [NREGS*8-1:0] regs_o,
  output logic               wr_strobe,
  output logic [PTR_W-1:0]   wr_addr,
  output logic [7:0]         wr_data,
  output logic               busy,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, PTR, DATA, DROP} state_t;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREGS - 1);

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic             do_wr, err_set, err_clr;
  logic             ptr_in_range;
  logic [7:0]       bank [NREGS];

  assign ptr_in_range = ({24'd0, data} < 32'(NREGS));
  assign busy         = (state != IDLE);

  // start overrides everything; a byte arriving with stop is handled before leaving.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    do_wr     = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    if (start) begin
      state_nxt = PTR;
      err_clr   = 1'b1;
    end else begin
      if (data_valid) begin
        case (state)
          PTR: begin
            if (ptr_in_range) begin
              ptr_nxt   = data[PTR_W-1:0];
              state_nxt = DATA;
            end else begin
              err_set   = 1'b1;
              state_nxt = DROP;
            end
          end
          DATA: begin
            do_wr = 1'b1;
            if (ptr == PTR_LAST) begin
              if (WRAP != 0) ptr_nxt = '0;
              else           state_nxt = DROP;
            end else begin
              ptr_nxt = ptr + 1'b1;
            end
          end
          DROP:    err_set = 1'b1;
          default: ;
        endcase
      end
      if (stop) state_nxt = IDLE;
    end
  end

  // write stage: bank update and strobe land one clock after data_valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      err       <= 1'b0;
      for (int k = 0; k < NREGS; k++) bank[k] <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      wr_strobe <= do_wr;
      if (do_wr) begin
        wr_addr   <= ptr;
        wr_data   <= data;
        bank[ptr] <= data;
      end
      if (err_clr)      err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NREGS; k++) regs_o[8*k +: 8] = bank[k];
  end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Scoreboard bench for i2c_reg_ctrl: a WRAP=0 and a WRAP=1 instance share stimulus,
// each compared against its own transaction-level reference model.
module tb_i2c_reg_ctrl;

  localparam int IDLE_S = 0, PTR_S = 1, DATA_S = 2, DROP_S = 3;

  typedef struct {
    int         due;
    logic [2:0] a;
    logic [7:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        data_valid = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;

  logic [63:0] regs [2];
  logic        ws   [2];
  logic [2:0]  wa   [2];
  logic [7:0]  wd   [2];
  logic        bs   [2];
  logic        er   [2];

  int   vec  = 0;
  int   miss = 0;
  int   cyc  = 0;
  exp_t q [2][$];

  int         m_state [2];
  int         m_ptr   [2];
  logic [7:0] m_regs  [2][8];
  logic       m_err   [2];

  i2c_reg_ctrl #(.NREGS(8), .PTR_W(3), .WRAP(0)) dut_nowrap (
    .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
    .start(start), .stop(stop), .regs_o(regs[0]), .wr_strobe(ws[0]),
    .wr_addr(wa[0]), .wr_data(wd[0]), .busy(bs[0]), .err(er[0]));

  i2c_reg_ctrl #(.NREGS(8), .PTR_W(3), .WRAP(1)) dut_wrap (
    .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
    .start(start), .stop(stop), .regs_o(regs[1]), .wr_strobe(ws[1]),
    .wr_addr(wa[1]), .wr_data(wd[1]), .busy(bs[1]), .err(er[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int w, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s (wrap=%0d) at cycle %0d: got %h, expected %h", nm, w, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_regs(input int w);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = m_regs[w][k];
    return r;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_state[w] = IDLE_S;
      m_ptr[w]   = 0;
      m_err[w]   = 1'b0;
      for (int k = 0; k < 8; k++) m_regs[w][k] = 8'd0;
      q[w].delete();
    end
  endtask

  // Transaction-level rules: start restarts, pointer byte selects, data bytes auto-increment.
  task automatic model_step(input int w, input logic st, input logic sp, input logic dv, input logic [7:0] d);
    exp_t e;
    if (st) begin
      m_err[w]   = 1'b0;
      m_state[w] = PTR_S;
      return;
    end
    if (dv) begin
      if (m_state[w] == PTR_S) begin
        if (d < 8) begin
          m_ptr[w]   = d;
          m_state[w] = DATA_S;
        end else begin
          m_err[w]   = 1'b1;
          m_state[w] = DROP_S;
        end
      end else if (m_state[w] == DATA_S) begin
        m_regs[w][m_ptr[w]] = d;
        e.due = cyc + 1;
        e.a   = 3'(m_ptr[w]);
        e.d   = d;
        q[w].push_back(e);
        if (m_ptr[w] == 7) begin
          if (w == 1) m_ptr[w] = 0;
          else        m_state[w] = DROP_S;
        end else begin
          m_ptr[w] = m_ptr[w] + 1;
        end
      end else if (m_state[w] == DROP_S) begin
        m_err[w] = 1'b1;
      end
    end
    if (sp) m_state[w] = IDLE_S;
  endtask

  task automatic check_state();
    for (int w = 0; w < 2; w++) begin
      chk("regs_o", w, regs[w], exp_regs(w));
      chk("err", w, 64'(er[w]), 64'(m_err[w]));
      chk("busy", w, 64'(bs[w]), 64'(m_state[w] != IDLE_S));
    end
  endtask

  // Called at a falling edge; inputs are held across one rising edge.
  task automatic step(input logic st, input logic sp, input logic dv, input logic [7:0] d);
    start = st; stop = sp; data_valid = dv; data = d;
    for (int w = 0; w < 2; w++) model_step(w, st, sp, dv, d);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; stop = 1'b0; data_valid = 1'b0;
    check_state();
  endtask

  task automatic reset_during(input logic [7:0] d);
    data = d; data_valid = 1'b1; reset = 1'b0;
    #1;
    model_reset();
    for (int w = 0; w < 2; w++) begin
      chk("reset_regs", w, regs[w], 64'd0);
      chk("reset_strobe", w, 64'(ws[w]), 64'd0);
      chk("reset_busy", w, 64'(bs[w]), 64'd0);
      chk("reset_err", w, 64'(er[w]), 64'd0);
    end
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0; reset = 1'b1;
    check_state();
  endtask

  // Monitor: every strobe must match the oldest expected write, on its due cycle.
  always @(negedge clk) begin
    if (reset) begin
      for (int w = 0; w < 2; w++) begin
        if (ws[w]) begin
          if (q[w].size() == 0) begin
            chk("unexpected_strobe", w, {53'd0, wa[w], wd[w]}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            exp_t e;
            e = q[w].pop_front();
            chk("write", w, {cyc, 21'd0, wa[w], wd[w]}, {e.due, 21'd0, e.a, e.d});
          end
        end else if (q[w].size() > 0 && q[w][0].due <= cyc) begin
          exp_t e;
          e = q[w].pop_front();
          chk("missing_strobe", w, 64'd0, {53'd1, e.a, e.d});
        end
      end
    end
  end

  initial begin
    model_reset();
    @(negedge clk);
    check_state();
    for (int w = 0; w < 2; w++) chk("reset_strobe", w, 64'(ws[w]), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // basic pointer + two writes
    step(1, 0, 0, 0); step(0, 0, 1, 8'h02); step(0, 0, 1, 8'h5A); step(0, 0, 1, 8'hC3);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    // out-of-range pointer, then err cleared by start
    step(1, 0, 0, 0); step(0, 0, 1, 8'h71); step(0, 0, 1, 8'hA8); step(0, 1, 0, 0);
    step(1, 0, 0, 0); step(0, 1, 0, 0);
    // last register: wrap vs. error
    step(1, 0, 0, 0); step(0, 0, 1, 8'h07); step(0, 0, 1, 8'h11); step(0, 0, 1, 8'h22);
    step(0, 0, 1, 8'h33); step(0, 1, 0, 0);
    // repeated start, start+data_valid, start+stop, stop+data_valid
    step(1, 0, 0, 0); step(0, 0, 1, 8'h01); step(0, 0, 1, 8'hAA); step(1, 0, 0, 0);
    step(0, 0, 1, 8'h04); step(0, 0, 1, 8'hBB); step(1, 0, 1, 8'h99); step(0, 0, 1, 8'h05);
    step(0, 0, 1, 8'h66); step(1, 1, 0, 0); step(0, 0, 1, 8'h06); step(0, 1, 1, 8'h77);
    step(0, 0, 0, 0);
    // data_valid while idle
    step(0, 0, 1, 8'h44); step(0, 0, 1, 8'h02);
    // reset during a data byte
    step(1, 0, 0, 0); step(0, 0, 1, 8'h03); reset_during(8'hEE);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      if ($urandom_range(0, 9) < 6) d = 8'($urandom_range(0, 9));
      else                          d = 8'($urandom_range(0, 255));
      if (i == 200) reset_during(d);
      else step($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 6,
                $urandom_range(0, 99) < 55, d);
    end

    step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    for (int w = 0; w < 2; w++) chk("pending_writes", w, 64'(q[w].size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
